// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: maps key press/release events onto NUM_VOICES envelope
// generators, stealing the least-recently-allocated voice when none is free.
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_W     = 7
) (
  input  logic                         clk,
  input  logic                         rst_b,
  input  logic                         key_valid,
  output logic                         key_ready,
  input  logic                         key_on,
  input  logic [NOTE_W-1:0]            key_note,
  input  logic [NUM_VOICES-1:0]        voice_busy,
  input  logic [NUM_VOICES-1:0]        voice_done,
  output logic [NUM_VOICES-1:0]        voice_note_on,
  output logic [NUM_VOICES-1:0]        voice_note_off,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic [NUM_VOICES-1:0]        voice_held,
  output logic                         steal,
  output logic                         miss
);
  localparam int RW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  typedef enum logic [1:0] {IDLE, DECIDE, WAIT_FREE} state_t;

  state_t                state_q, state_d;
  logic                  req_on_q, req_on_d;
  logic [NOTE_W-1:0]     req_note_q, req_note_d;
  logic [NUM_VOICES-1:0] alloc_q, alloc_d;
  logic [NUM_VOICES-1:0] held_q, held_d;
  logic [NUM_VOICES-1:0] note_on_q, note_on_d;
  logic [NUM_VOICES-1:0] note_off_q, note_off_d;
  logic                  steal_q, steal_d;
  logic                  miss_q, miss_d;
  logic [RW-1:0]         victim_q, victim_d;
  logic [NOTE_W-1:0]     note_q [NUM_VOICES];
  logic [NOTE_W-1:0]     note_d [NUM_VOICES];
  logic [RW-1:0]         rank_q [NUM_VOICES];
  logic [RW-1:0]         rank_d [NUM_VOICES];

  logic [NUM_VOICES-1:0] free;
  logic                  free_any, match_hit, vic_any, do_alloc;
  logic [RW-1:0]         free_idx, match_idx, vic_idx, vic_rank, alloc_idx;

  assign key_ready = (state_q == IDLE);

  // Candidate selection: lowest free index, lowest held match, oldest victim.
  always_comb begin
    free      = ~alloc_q & ~voice_busy;
    free_any  = 1'b0;
    free_idx  = '0;
    match_hit = 1'b0;
    match_idx = '0;
    vic_any   = 1'b0;
    vic_idx   = '0;
    vic_rank  = '1;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (free[i] && !free_any) begin
        free_any = 1'b1;
        free_idx = RW'(i);
      end
      if (held_q[i] && (note_q[i] == req_note_q) && !match_hit) begin
        match_hit = 1'b1;
        match_idx = RW'(i);
      end
      if (alloc_q[i] && !held_q[i] && (!vic_any || (rank_q[i] < vic_rank))) begin
        vic_any  = 1'b1;
        vic_idx  = RW'(i);
        vic_rank = rank_q[i];
      end
    end
    // Released-but-sounding voices are preferred; fall back to any allocated voice.
    if (!vic_any) begin
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        if (alloc_q[i] && (!vic_any || (rank_q[i] < vic_rank))) begin
          vic_any  = 1'b1;
          vic_idx  = RW'(i);
          vic_rank = rank_q[i];
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    req_on_d   = req_on_q;
    req_note_d = req_note_q;
    victim_d   = victim_q;
    alloc_d    = alloc_q & ~voice_done;
    held_d     = held_q & ~voice_done;
    note_on_d  = '0;
    note_off_d = '0;
    steal_d    = 1'b0;
    miss_d     = 1'b0;
    note_d     = note_q;
    rank_d     = rank_q;
    do_alloc   = 1'b0;
    alloc_idx  = '0;
    case (state_q)
      IDLE: begin
        if (key_valid) begin
          req_on_d   = key_on;
          req_note_d = key_note;
          state_d    = DECIDE;
        end
      end
      DECIDE: begin
        if (!req_on_q) begin
          if (match_hit) begin
            note_off_d[match_idx] = 1'b1;
            held_d[match_idx]     = 1'b0;
          end else begin
            miss_d = 1'b1;
          end
          state_d = IDLE;
        end else if (match_hit) begin
          state_d = IDLE;
        end else if (free_any) begin
          do_alloc  = 1'b1;
          alloc_idx = free_idx;
          state_d   = IDLE;
        end else if (vic_any) begin
          victim_d = vic_idx;
          steal_d  = 1'b1;
          if (held_q[vic_idx]) begin
            note_off_d[vic_idx] = 1'b1;
            held_d[vic_idx]     = 1'b0;
          end
          state_d = WAIT_FREE;
        end
      end
      WAIT_FREE: begin
        if (voice_done[victim_q]) begin
          do_alloc  = 1'b1;
          alloc_idx = victim_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Allocation overrides a same-cycle done clear on that voice.
    if (do_alloc) begin
      note_on_d[alloc_idx] = 1'b1;
      note_d[alloc_idx]    = req_note_q;
      held_d[alloc_idx]    = 1'b1;
      alloc_d[alloc_idx]   = 1'b1;
      for (int unsigned j = 0; j < NUM_VOICES; j++) begin
        if (rank_q[j] > rank_q[alloc_idx]) rank_d[j] = rank_q[j] - RW'(1);
      end
      rank_d[alloc_idx] = RW'(NUM_VOICES - 1);
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= IDLE;
      req_on_q   <= 1'b0;
      req_note_q <= '0;
      alloc_q    <= '0;
      held_q     <= '0;
      note_on_q  <= '0;
      note_off_q <= '0;
      steal_q    <= 1'b0;
      miss_q     <= 1'b0;
      victim_q   <= '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= '0;
        rank_q[i] <= RW'(i);
      end
    end else begin
      state_q    <= state_d;
      req_on_q   <= req_on_d;
      req_note_q <= req_note_d;
      alloc_q    <= alloc_d;
      held_q     <= held_d;
      note_on_q  <= note_on_d;
      note_off_q <= note_off_d;
      steal_q    <= steal_d;
      miss_q     <= miss_d;
      victim_q   <= victim_d;
      note_q     <= note_d;
      rank_q     <= rank_d;
    end
  end

  always_comb begin
    voice_note = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) voice_note[i*NOTE_W +: NOTE_W] = note_q[i];
  end

  assign voice_note_on  = note_on_q;
  assign voice_note_off = note_off_q;
  assign voice_held     = held_q;
  assign steal          = steal_q;
  assign miss           = miss_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed vector table, hand-written steal/reset sequences,
// and a randomized run against a queue-based LRU model with simple envelope stand-ins.
module tb_voice_allocator;
  localparam int NV = 4;
  localparam int NW = 7;

  logic             clk = 1'b0;
  logic             rst_b = 1'b0;
  logic             key_valid = 1'b0;
  logic             key_on = 1'b0;
  logic [NW-1:0]    key_note = '0;
  logic [NV-1:0]    voice_busy = '0;
  logic [NV-1:0]    voice_done = '0;
  logic             key_ready;
  logic [NV-1:0]    voice_note_on, voice_note_off, voice_held;
  logic [NV*NW-1:0] voice_note;
  logic             steal, miss;

  always #5 clk = ~clk;

  voice_allocator #(.NUM_VOICES(NV), .NOTE_W(NW)) dut (
    .clk(clk), .rst_b(rst_b), .key_valid(key_valid), .key_ready(key_ready),
    .key_on(key_on), .key_note(key_note), .voice_busy(voice_busy), .voice_done(voice_done),
    .voice_note_on(voice_note_on), .voice_note_off(voice_note_off), .voice_note(voice_note),
    .voice_held(voice_held), .steal(steal), .miss(miss)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          on;
    logic [NW-1:0] note;
    logic [NV-1:0] e_on;
    logic [NV-1:0] e_off;
    logic [NV-1:0] e_held;
    logic          e_miss;
  } vec_t;
  vec_t tbl[8];

  // Issue one event from IDLE; returns at the negedge after the accept edge.
  task automatic send(input logic on, input logic [NW-1:0] note);
    int unsigned t;
    t = 0;
    while (!key_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("ready_before_send", key_ready, 1);
    key_valid = 1'b1;
    key_on    = on;
    key_note  = note;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_b      = 1'b0;
    key_valid  = 1'b0;
    voice_busy = '0;
    voice_done = '0;
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
  endtask

  task automatic press4();
    send(1'b1, NW'(60)); @(negedge clk);
    send(1'b1, NW'(62)); @(negedge clk);
    send(1'b1, NW'(64)); @(negedge clk);
    send(1'b1, NW'(67)); @(negedge clk);
  endtask

  // Reference model: LRU kept as a queue of voice indices, oldest first.
  int            m_phase;
  logic          m_req_on;
  logic [NW-1:0] m_req_note;
  int            m_vic;
  bit            m_alloc[NV];
  bit            m_held[NV];
  logic [NW-1:0] m_note[NV];
  int            order[$];
  logic [NV-1:0] x_on, x_off, x_held;
  logic          x_steal, x_miss;
  logic [NV*NW-1:0] x_note;

  int env_rel[NV];
  bit env_busy[NV];
  bit env_done[NV];

  task automatic model_reset();
    m_phase = 0; m_req_on = 1'b0; m_req_note = '0; m_vic = 0;
    order.delete();
    for (int i = 0; i < NV; i++) begin
      m_alloc[i] = 0; m_held[i] = 0; m_note[i] = '0; order.push_back(i);
      env_rel[i] = 0; env_busy[i] = 0; env_done[i] = 0;
    end
    x_on = '0; x_off = '0; x_held = '0; x_steal = 1'b0; x_miss = 1'b0; x_note = '0;
  endtask

  task automatic model_step(input bit kv, input bit kon, input logic [NW-1:0] kn,
                            input logic [NV-1:0] busy, input logic [NV-1:0] done);
    int av, hit, fr, vic;
    int tmp[$];
    av = -1; hit = -1; fr = -1; vic = -1;
    x_on = '0; x_off = '0; x_steal = 1'b0; x_miss = 1'b0;
    for (int i = NV - 1; i >= 0; i--) begin
      if (m_held[i] && m_note[i] == m_req_note) hit = i;
      if (!m_alloc[i] && !busy[i]) fr = i;
    end
    case (m_phase)
      0: if (kv) begin m_req_on = kon; m_req_note = kn; m_phase = 1; end
      1: begin
        if (!m_req_on) begin
          if (hit >= 0) begin x_off[hit] = 1'b1; m_held[hit] = 0; end
          else x_miss = 1'b1;
          m_phase = 0;
        end else if (hit >= 0) begin
          m_phase = 0;
        end else if (fr >= 0) begin
          av = fr; m_phase = 0;
        end else begin
          foreach (order[k]) if (vic < 0 && m_alloc[order[k]] && !m_held[order[k]]) vic = order[k];
          foreach (order[k]) if (vic < 0 && m_alloc[order[k]]) vic = order[k];
          if (vic >= 0) begin
            m_vic = vic; x_steal = 1'b1;
            if (m_held[vic]) begin x_off[vic] = 1'b1; m_held[vic] = 0; end
            m_phase = 2;
          end
        end
      end
      default: if (done[m_vic]) begin av = m_vic; m_phase = 0; end
    endcase
    for (int i = 0; i < NV; i++) if (done[i] && i != av) begin m_alloc[i] = 0; m_held[i] = 0; end
    if (av >= 0) begin
      x_on[av] = 1'b1; m_alloc[av] = 1; m_held[av] = 1; m_note[av] = m_req_note;
      foreach (order[k]) if (order[k] != av) tmp.push_back(order[k]);
      tmp.push_back(av);
      order = tmp;
    end
    for (int i = 0; i < NV; i++) begin
      x_held[i] = m_held[i];
      x_note[i*NW +: NW] = m_note[i];
    end
  endtask

  initial begin
    bit kv, kon;
    logic [NW-1:0] kn;

    tbl[0] = '{1'b1, NW'(60), 4'b0001, 4'b0000, 4'b0001, 1'b0};
    tbl[1] = '{1'b1, NW'(62), 4'b0010, 4'b0000, 4'b0011, 1'b0};
    tbl[2] = '{1'b1, NW'(64), 4'b0100, 4'b0000, 4'b0111, 1'b0};
    tbl[3] = '{1'b1, NW'(67), 4'b1000, 4'b0000, 4'b1111, 1'b0};
    tbl[4] = '{1'b1, NW'(62), 4'b0000, 4'b0000, 4'b1111, 1'b0};
    tbl[5] = '{1'b0, NW'(62), 4'b0000, 4'b0010, 4'b1101, 1'b0};
    tbl[6] = '{1'b0, NW'(70), 4'b0000, 4'b0000, 4'b1101, 1'b1};
    tbl[7] = '{1'b0, NW'(62), 4'b0000, 4'b0000, 4'b1101, 1'b1};

    @(negedge clk);
    check("rst_ready", key_ready, 1);
    check("rst_pulses", {voice_note_on, voice_note_off, steal, miss}, 0);
    check("rst_held", voice_held, 0);
    check("rst_note", voice_note, 0);
    do_reset();

    for (int k = 0; k < 8; k++) begin
      send(tbl[k].on, tbl[k].note);
      check($sformatf("t%0d_ready_decide", k), key_ready, 0);
      @(negedge clk);
      check($sformatf("t%0d_note_on", k), voice_note_on, tbl[k].e_on);
      check($sformatf("t%0d_note_off", k), voice_note_off, tbl[k].e_off);
      check($sformatf("t%0d_miss", k), miss, tbl[k].e_miss);
      check($sformatf("t%0d_steal", k), steal, 0);
      check($sformatf("t%0d_held", k), voice_held, tbl[k].e_held);
      @(negedge clk);
      check($sformatf("t%0d_pulse_width", k), {voice_note_on, voice_note_off, miss}, 0);
    end
    check("t_notes", voice_note, {NW'(67), NW'(64), NW'(62), NW'(60)});

    // Steal of a held voice, then LRU order observed through the next steal.
    do_reset();
    press4();
    send(1'b1, NW'(72));
    @(negedge clk);
    check("a_steal", steal, 1);
    check("a_off", voice_note_off, 4'b0001);
    check("a_ready", key_ready, 0);
    repeat (4) @(negedge clk);
    check("a_wait_ready", key_ready, 0);
    check("a_wait_on", voice_note_on, 0);
    voice_done = 4'b0001;
    @(negedge clk);
    voice_done = '0;
    check("a_on", voice_note_on, 4'b0001);
    check("a_note0", voice_note[NW-1:0], 72);
    check("a_held", voice_held, 4'b1111);
    check("a_ready_after", key_ready, 1);
    send(1'b1, NW'(74));
    @(negedge clk);
    check("a2_steal", steal, 1);
    check("a2_off", voice_note_off, 4'b0010);
    voice_done = 4'b0010;
    @(negedge clk);
    voice_done = '0;
    check("a2_on", voice_note_on, 4'b0010);
    check("a2_note1", voice_note[2*NW-1:NW], 74);

    // Victim already released: no note_off.
    do_reset();
    press4();
    send(1'b0, NW'(64));
    @(negedge clk);
    check("b_rel_off", voice_note_off, 4'b0100);
    send(1'b1, NW'(48));
    @(negedge clk);
    check("b_steal", steal, 1);
    check("b_no_off", voice_note_off, 0);
    repeat (3) @(negedge clk);
    voice_done = 4'b0100;
    @(negedge clk);
    voice_done = '0;
    check("b_on", voice_note_on, 4'b0100);
    check("b_note2", voice_note[3*NW-1:2*NW], 48);

    // done in IDLE frees a voice for the next press.
    do_reset();
    press4();
    voice_busy = 4'b1111;
    send(1'b0, NW'(62));
    @(negedge clk);
    check("c_off", voice_note_off, 4'b0010);
    voice_done = 4'b0010;
    @(negedge clk);
    voice_done = '0;
    voice_busy = 4'b1101;
    check("c_held", voice_held, 4'b1101);
    send(1'b1, NW'(80));
    @(negedge clk);
    check("c_on", voice_note_on, 4'b0010);
    check("c_steal", steal, 0);

    // Reset during WAIT_FREE, then orphan busy voices block allocation.
    do_reset();
    press4();
    voice_busy = 4'b1111;
    send(1'b1, NW'(72));
    @(negedge clk);
    check("d_steal", steal, 1);
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    check("d_rst_ready", key_ready, 1);
    check("d_rst_pulses", {voice_note_on, voice_note_off, steal, miss}, 0);
    check("d_rst_held", voice_held, 0);
    check("d_rst_note", voice_note, 0);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    send(1'b1, NW'(50));
    repeat (3) @(negedge clk);
    check("d_orphan_ready", key_ready, 0);
    check("d_orphan_on", voice_note_on, 0);
    voice_busy = 4'b1011;
    @(negedge clk);
    check("d_on", voice_note_on, 4'b0100);
    check("d_note2", voice_note[3*NW-1:2*NW], 50);

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      check("r_on", voice_note_on, x_on);
      check("r_off", voice_note_off, x_off);
      check("r_steal", steal, x_steal);
      check("r_miss", miss, x_miss);
      check("r_held", voice_held, x_held);
      check("r_ready", key_ready, (m_phase == 0) ? 1 : 0);
      check("r_note", voice_note, x_note);
      for (int i = 0; i < NV; i++) begin
        if (voice_note_on[i]) begin
          env_busy[i] = 1; env_rel[i] = 0; env_done[i] = 0;
        end else if (env_done[i]) begin
          env_done[i] = 0; env_busy[i] = 0;
        end else if (voice_note_off[i]) begin
          env_rel[i] = int'($urandom_range(2, 6));
        end else if (env_rel[i] > 0) begin
          env_rel[i]--;
          if (env_rel[i] == 0) env_done[i] = 1;
        end
        voice_busy[i] = env_busy[i];
        voice_done[i] = env_done[i];
      end
      kv  = ($urandom_range(0, 3) != 0);
      kon = ($urandom_range(0, 2) != 0);
      kn  = NW'(60 + $urandom_range(0, 5));
      key_valid = kv;
      key_on    = kon;
      key_note  = kn;
      model_step(kv, kon, kn, voice_busy, voice_done);
      @(negedge clk);
    end
    key_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
